pwm_ramp_ctrl: RTL
==================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter STEP, default 8, giving the duty change applied per PWM period.
REQ-002 The block SHALL have parameter DUTY_W, default 10, giving the duty and period-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is posedge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port tgt_duty, input, DUTY_W bits: requested target duty.
REQ-006 The block SHALL have port tgt_vld, input, 1 bit: target valid.
REQ-007 The block SHALL have port tgt_rdy, output, 1 bit: block accepts a target.
REQ-008 The block SHALL have port cur_duty, output, DUTY_W bits: duty currently applied to the PWM.
REQ-009 The block SHALL have port ramp_done, output, 1 bit: one-cycle pulse when cur_duty reaches the target.
REQ-010 The block SHALL have port PWM_sig, output, 1 bit: PWM waveform driven by cur_duty.

Function
REQ-011 The block SHALL run a free-running DUTY_W-bit period counter from 0, wrapping 1023->0; tick = (counter == 1023).
REQ-012 The block SHALL run a two-state FSM: IDLE (tgt_rdy=1) and RAMP (tgt_rdy=0).
REQ-013 In IDLE, tgt_vld & tgt_rdy SHALL capture tgt_duty into a target register and move the FSM to RAMP on the same edge.
REQ-014 In RAMP, tgt_vld SHALL be ignored and no new target captured.
REQ-015 cur_duty SHALL change only on a tick edge, so that each new value is first valid during period count 0.
REQ-016 On a RAMP tick, if |target - cur_duty| <= STEP, cur_duty SHALL load the target, and the FSM SHALL go to IDLE and assert ramp_done for the following cycle only.
REQ-017 On a RAMP tick, if |target - cur_duty| > STEP, cur_duty SHALL move STEP toward the target.
REQ-018 The difference SHALL be computed at DUTY_W+1 bits; cur_duty SHALL never wrap below 0 or above 1023.
REQ-019 A target equal to cur_duty SHALL still enter RAMP and complete on the next tick with a ramp_done pulse.
REQ-020 A handshake on the tick edge itself SHALL capture the target without changing cur_duty on that edge.
REQ-021 PWM_sig SHALL rise on the edge where the counter is 1023 and fall on the edge where the counter equals cur_duty, giving cur_duty+1 high clocks per 1024-clock period.
REQ-022 The PWM counter and the period counter SHALL remain phase-aligned at all times.

Reset
REQ-023 rst_n low SHALL asynchronously force: counters 0, FSM IDLE, cur_duty 0, target 0, ramp_done 0, PWM_sig 1.
REQ-024 Reset asserted mid-ramp SHALL discard the captured target with no ramp_done pulse; the block SHALL restart in IDLE with tgt_rdy=1 on the first edge after release.

Configuration
REQ-025 With macro PWM_RAMP_BRAKE_EN defined, the block SHALL add input port brake (1 bit).
REQ-026 With PWM_RAMP_BRAKE_EN defined, brake high SHALL force cur_duty to 0 on the next edge regardless of tick, force FSM to IDLE, hold tgt_rdy=0, and suppress ramp_done.
REQ-027 With PWM_RAMP_BRAKE_EN defined, after brake deasserts tgt_rdy SHALL return to 1 on the next cycle.
REQ-028 With PWM_RAMP_BRAKE_EN undefined, the brake port and its logic SHALL be absent, and behaviour SHALL be exactly as REQ-011 to REQ-022.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, RAMP), the DUTY_W default and the period-max constant 1023.
REQ-030 PWM_sig SHALL be produced by instantiating the existing pwm sub-module with cur_duty as its duty input; no other sub-modules SHALL be used.

Verification (STEP=8)
REQ-031 From reset, tgt_duty=40 -> cur_duty SHALL be 8,16,24,32,40 on ticks 1-5; ramp_done SHALL pulse once in the cycle after tick 5; tgt_rdy SHALL return to 1.
REQ-032 From cur_duty=32, tgt_duty=37 -> on the next tick cur_duty SHALL be 37 with a ramp_done pulse; from 37, tgt_duty=0 -> 29,21,13,5,0.
REQ-033 tgt_vld=1 with tgt_duty=100 held throughout a ramp to 40 -> value 100 SHALL be accepted only after ramp_done, and cur_duty SHALL then continue 48,56,...
REQ-034 cur_duty=40 held -> PWM_sig SHALL be high for exactly 41 of every 1024 clocks; with cur_duty=0, high for exactly 1 clock.
REQ-035 rst_n pulsed low at cur_duty=24 during a ramp to 40 -> cur_duty SHALL be 0, tgt_rdy SHALL be 1, and no ramp_done SHALL occur.
REQ-036 (PWM_RAMP_BRAKE_EN) brake=1 mid-ramp at cur_duty=16 -> cur_duty SHALL be 0 on the next edge without waiting for a tick, and tgt_rdy SHALL be 0 until brake=0.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and constants for the PWM duty ramp controller.
package pwm_ramp_ctrl_pkg;

    localparam int DUTY_W_DEF = 10;

    function automatic int period_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int PERIOD_MAX = period_max(DUTY_W_DEF);  // 1023

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_pwm.sv
// PWM generator: high from period count 0 through count == duty, so duty+1 high clocks per period.
module pwm
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int W = DUTY_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] duty,
    output logic         pwm_out
);

    localparam logic [W-1:0] CNT_MAX = W'(period_max(W));

    logic [W-1:0] cnt;

    // Rise has priority so duty == CNT_MAX yields a permanently high output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pwm_out <= 1'b1;
        end else begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            if (cnt == CNT_MAX)
                pwm_out <= 1'b1;
            else if (cnt == duty)
                pwm_out <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the applied PWM duty toward an accepted target by STEP once per period.
// Optional brake input enabled by defining PWM_RAMP_BRAKE_EN.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int STEP   = 8,
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_vld,
`ifdef PWM_RAMP_BRAKE_EN
    input  logic              brake,
`endif
    output logic              tgt_rdy,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              ramp_done,
    output logic              PWM_sig
);

    localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(period_max(DUTY_W));
    localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(STEP);

    logic [DUTY_W-1:0] cnt;
    logic              tick;
    state_e            state_q, state_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d, cur_d;
    logic              done_d;
    logic [DUTY_W:0]   diff, mag;
    logic              up;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

`ifdef PWM_RAMP_BRAKE_EN
    logic brake_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) brake_q <= 1'b0;
        else        brake_q <= brake;
    end

    // Ready stays low for one extra cycle after brake releases.
    assign tgt_rdy = (state_q == IDLE) && !brake && !brake_q;
`else
    assign tgt_rdy = (state_q == IDLE);
`endif

    // Extended-width difference keeps the sign, so stepping never wraps.
    assign diff = {1'b0, tgt_q} - {1'b0, cur_duty};
    assign up   = !diff[DUTY_W];
    assign mag  = up ? diff : (~diff + 1'b1);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_duty;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt_vld && tgt_rdy) begin
                    tgt_d   = tgt_duty;
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (tick) begin
                    if (mag <= STEP_X) begin
                        cur_d   = tgt_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_d = up ? cur_duty + DUTY_W'(STEP) : cur_duty - DUTY_W'(STEP);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PWM_RAMP_BRAKE_EN
        if (brake) begin
            cur_d   = '0;
            done_d  = 1'b0;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            cur_duty  <= '0;
            ramp_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_duty  <= cur_d;
            ramp_done <= done_d;
        end
    end

    pwm #(.W(DUTY_W)) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (cur_duty),
        .pwm_out(PWM_sig)
    );

endmodule
